// File: rtl/pix_fifo_pkg.sv
// Shared constants and parameter-legality check for the pixel sync FIFO.
package pix_fifo_pkg;

   localparam int unsigned PIX_DATA_WIDTH  = 240;
   localparam int unsigned PIX_DEPTH_WIDTH = 5;

   function automatic bit pix_params_legal(
      input int unsigned data_width,
      input int unsigned depth_width,
      input int unsigned almost_full_num,
      input int unsigned almost_empty_num
   );
      int unsigned depth;
      depth = 32'd1 << depth_width;
      return (data_width >= 1) && (data_width <= 1152) &&
             (depth_width >= 2) && (depth_width <= 12) &&
             (almost_full_num >= 1) && (almost_full_num <= depth) &&
             (almost_empty_num < depth) &&
             (almost_empty_num < almost_full_num);
   endfunction

endpackage

// File: rtl/pix_fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port (block-RAM style, no reset).
module pix_fifo_ram
   import pix_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = PIX_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = PIX_DEPTH_WIDTH
) (
   input  logic                  i_clk,
   input  logic                  i_wr_en,
   input  logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_rd_en,
   input  logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic [DATA_WIDTH-1:0] o_rd_data
);

   logic [DATA_WIDTH-1:0] r_mem [0:(1 << ADDR_WIDTH)-1];
   logic [DATA_WIDTH-1:0] r_rd_data;

   always_ff @(posedge i_clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
      if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/pix_sync_fifo.sv
// Single-clock pixel FIFO with registered level/flags, sticky over/underflow and
// an optional extra output register on the read path.
module pix_sync_fifo
   import pix_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH       = PIX_DATA_WIDTH,
   parameter int unsigned DEPTH_WIDTH      = PIX_DEPTH_WIDTH,
   parameter int unsigned OUTPUT_REG       = 1,
   parameter int unsigned ALMOST_FULL_NUM  = 25,
   parameter int unsigned ALMOST_EMPTY_NUM = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   wr_en,
   input  logic [DATA_WIDTH-1:0]  wr_data,
   output logic                   wr_full,
   output logic                   almost_full,
   input  logic                   rd_en,
   output logic [DATA_WIDTH-1:0]  rd_data,
   output logic                   rd_valid,
   output logic                   rd_empty,
   output logic                   almost_empty,
   output logic [DEPTH_WIDTH:0]   water_level,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int unsigned LW = DEPTH_WIDTH + 1;
   localparam logic [LW-1:0] C_DEPTH = LW'(32'd1 << DEPTH_WIDTH);
   localparam logic [LW-1:0] C_AF    = LW'(ALMOST_FULL_NUM);
   localparam logic [LW-1:0] C_AE    = LW'(ALMOST_EMPTY_NUM);

   if (!pix_params_legal(DATA_WIDTH, DEPTH_WIDTH, ALMOST_FULL_NUM, ALMOST_EMPTY_NUM)) begin : g_param_check
      $error("pix_sync_fifo: illegal parameter combination");
   end

   logic [DEPTH_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
   logic [LW-1:0]          r_level;
   logic                   r_full, r_empty, r_af, r_ae, r_ovf, r_unf;
   logic                   r_v1;
   logic                   w_wr_acc, w_rd_acc;
   logic [LW-1:0]          w_level_nxt;
   logic [DATA_WIDTH-1:0]  w_ram_q, w_pipe_data;
   logic                   w_pipe_valid;

   assign w_wr_acc    = wr_en & ~r_full  & ~flush & ~rst;
   assign w_rd_acc    = rd_en & ~r_empty & ~flush & ~rst;
   assign w_level_nxt = r_level + LW'(w_wr_acc) - LW'(w_rd_acc);

   pix_fifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (DEPTH_WIDTH)
   ) u_ram (
      .i_clk     (clk),
      .i_wr_en   (w_wr_acc),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (wr_data),
      .i_rd_en   (w_rd_acc),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_ram_q)
   );

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_af     <= 1'b0;
         r_ae     <= 1'b1;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
         r_v1     <= 1'b0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + DEPTH_WIDTH'(1);
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + DEPTH_WIDTH'(1);
         r_level <= w_level_nxt;
         // Flags come from the next level so they line up with water_level.
         r_full  <= (w_level_nxt == C_DEPTH);
         r_empty <= (w_level_nxt == '0);
         r_af    <= (w_level_nxt >= C_AF);
         r_ae    <= (w_level_nxt <= C_AE);
         if (wr_en && r_full)  r_ovf <= 1'b1;
         if (rd_en && r_empty) r_unf <= 1'b1;
         r_v1 <= w_rd_acc;
      end
   end

   if (OUTPUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] r_q2;
      logic                  r_v2;
      always_ff @(posedge clk) begin
         if (rst || flush) r_v2 <= 1'b0;
         else              r_v2 <= r_v1;
         if (r_v1) r_q2 <= w_ram_q;
      end
      assign w_pipe_data  = r_q2;
      assign w_pipe_valid = r_v2;
   end else begin : g_noreg
      assign w_pipe_data  = w_ram_q;
      assign w_pipe_valid = r_v1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= w_pipe_valid & ~flush;
         if (w_pipe_valid && !flush) rd_data <= w_pipe_data;
      end
   end

   assign wr_full      = r_full;
   assign almost_full  = r_af;
   assign rd_empty     = r_empty;
   assign almost_empty = r_ae;
   assign water_level  = r_level;
   assign overflow     = r_ovf;
   assign underflow    = r_unf;

endmodule

// File: tb/tb_pix_sync_fifo.sv
// Self-checking bench for pix_sync_fifo against a queue-based reference model.
module tb_pix_sync_fifo;

   localparam int DW    = 240;
   localparam int AW    = 5;
   localparam int DEPTH = 32;
   localparam int AF    = 25;
   localparam int AE    = 6;
   localparam int LAT   = 2;

   logic          clk = 1'b0;
   logic          rst, flush, wr_en, rd_en;
   logic [DW-1:0] wr_data;
   logic          wr_full, almost_full, rd_valid, rd_empty, almost_empty, overflow, underflow;
   logic [DW-1:0] rd_data;
   logic [AW:0]   water_level;

   always #5 clk = ~clk;

   pix_sync_fifo #(
      .DATA_WIDTH       (DW),
      .DEPTH_WIDTH      (AW),
      .OUTPUT_REG       (1),
      .ALMOST_FULL_NUM  (AF),
      .ALMOST_EMPTY_NUM (AE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .wr_full      (wr_full),
      .almost_full  (almost_full),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .rd_empty     (rd_empty),
      .almost_empty (almost_empty),
      .water_level  (water_level),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: contents as a queue, pops scheduled LAT edges later.
   typedef struct { int due; logic [DW-1:0] data; } pend_t;
   logic [DW-1:0] mq[$];
   pend_t         mp[$];
   bit            m_ov, m_un, m_rdv;
   logic [DW-1:0] m_rdd;
   int            cyc = 0;

   function automatic logic [5:0] exp_flags();
      return {mq.size() == DEPTH, mq.size() >= AF, mq.size() == 0,
              mq.size() <= AE, m_ov, m_un};
   endfunction

   function automatic logic [DW-1:0] rand_word();
      logic [DW-1:0] w = '0;
      for (int i = 0; i < (DW + 31) / 32; i++) w = (w << 32) | DW'($urandom);
      return w;
   endfunction

   task automatic step(input bit w, input bit r, input bit f, input bit s, input logic [DW-1:0] d);
      bit full, empty;
      pend_t p;
      wr_en = w; rd_en = r; flush = f; rst = s; wr_data = d;
      @(posedge clk);
      cyc++;
      if (s || f) begin
         mq.delete(); mp.delete();
         m_ov = 0; m_un = 0; m_rdv = 0;
         if (s) m_rdd = '0;
      end else begin
         full  = (mq.size() == DEPTH);
         empty = (mq.size() == 0);
         if (w && full)  m_ov = 1;
         if (r && empty) m_un = 1;
         if (r && !empty) begin
            p.due = cyc + LAT; p.data = mq.pop_front(); mp.push_back(p);
         end
         if (w && !full) mq.push_back(d);
         m_rdv = 0;
         if (mp.size() > 0 && mp[0].due == cyc) begin
            m_rdv = 1; m_rdd = mp[0].data; void'(mp.pop_front());
         end
      end
      #1;
      wr_en = 0; rd_en = 0; flush = 0; rst = 0;
   endtask

   task automatic test_reset();
      step(0, 0, 0, 1, '0);
      step(1, 1, 0, 1, rand_word());
      checks++; if (water_level !== '0) begin errors++; $display("FAIL reset_level: got %0d expected 0", water_level); end
      checks++; if ({wr_full, almost_full, rd_empty, almost_empty} !== 4'b0011) begin errors++; $display("FAIL reset_flags: got %b expected 0011", {wr_full, almost_full, rd_empty, almost_empty}); end
      checks++; if ({rd_valid, overflow, underflow} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b expected 000", {rd_valid, overflow, underflow}); end
      checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) begin
         step(1, 0, 0, 0, DW'(i));
         checks++; if (water_level !== (AW+1)'(i + 1)) begin errors++; $display("FAIL fill_level: got %0d expected %0d", water_level, i + 1); end
         checks++; if (almost_full !== (i + 1 >= AF)) begin errors++; $display("FAIL fill_almost_full lvl=%0d: got %b expected %b", i + 1, almost_full, (i + 1 >= AF)); end
         checks++; if ({wr_full, almost_full, rd_empty, almost_empty, overflow, underflow} !== exp_flags()) begin errors++; $display("FAIL fill_flags: got %b expected %b", {wr_full, almost_full, rd_empty, almost_empty, overflow, underflow}, exp_flags()); end
      end
      checks++; if ({wr_full, overflow} !== 2'b10) begin errors++; $display("FAIL fill_end: got full/ovf=%b expected 10", {wr_full, overflow}); end
   endtask

   task automatic test_overflow_drain();
      int nrx = 0;
      step(1, 0, 0, 0, DW'(999));
      checks++; if (overflow !== 1'b1 || water_level !== (AW+1)'(DEPTH)) begin errors++; $display("FAIL overflow: got ovf=%b lvl=%0d expected ovf=1 lvl=32", overflow, water_level); end
      for (int i = 0; i < DEPTH + 3; i++) begin
         step(0, i < DEPTH, 0, 0, '0);
         checks++; if (rd_valid !== m_rdv || rd_data !== m_rdd) begin errors++; $display("FAIL drain_out cyc=%0d: got v=%b d=%h expected v=%b d=%h", cyc, rd_valid, rd_data, m_rdv, m_rdd); end
         if (rd_valid === 1'b1) begin
            checks++; if (rd_data !== DW'(nrx)) begin errors++; $display("FAIL drain_seq: got %h expected %0d", rd_data, nrx); end
            nrx++;
         end
      end
      checks++; if (nrx !== DEPTH || rd_empty !== 1'b1) begin errors++; $display("FAIL drain_end: got pops=%0d empty=%b expected 32/1", nrx, rd_empty); end
   endtask

   task automatic test_wrap();
      step(0, 0, 1, 0, '0);
      for (int i = 0; i < 10; i++) step(1, 0, 0, 0, rand_word());
      for (int i = 0; i < 100 + 13; i++) begin
         if (i < 100) step(1, 1, 0, 0, rand_word());
         else         step(0, 1, 0, 0, '0);
         if (i < 100) begin
            checks++; if (water_level !== (AW+1)'(10)) begin errors++; $display("FAIL wrap_level: got %0d expected 10", water_level); end
         end
         checks++; if (rd_valid !== m_rdv || rd_data !== m_rdd) begin errors++; $display("FAIL wrap_out cyc=%0d: got v=%b d=%h expected v=%b d=%h", cyc, rd_valid, rd_data, m_rdv, m_rdd); end
      end
   endtask

   task automatic test_underflow();
      step(1, 1, 0, 0, rand_word());
      checks++; if (underflow !== 1'b1 || water_level !== (AW+1)'(1)) begin errors++; $display("FAIL underflow: got unf=%b lvl=%0d expected 1/1", underflow, water_level); end
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, '0);
         checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL underflow_novalid: got %b expected 0", rd_valid); end
      end
      for (int i = 0; i < 4; i++) begin
         step(0, i == 0, 0, 0, '0);
         checks++; if (rd_valid !== m_rdv || rd_data !== m_rdd) begin errors++; $display("FAIL underflow_out: got v=%b d=%h expected v=%b d=%h", rd_valid, rd_data, m_rdv, m_rdd); end
      end
   endtask

   task automatic test_flush();
      step(0, 1, 0, 0, '0);
      for (int i = 0; i < 20; i++) step(1, 0, 0, 0, rand_word());
      step(0, 1, 0, 0, '0);
      step(0, 1, 0, 0, '0);
      step(0, 0, 1, 0, '0);
      for (int i = 0; i < 4; i++) begin
         checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL flush_novalid: got %b expected 0", rd_valid); end
         checks++; if ({water_level, rd_empty, wr_full, overflow, underflow} !== {(AW+1)'(0), 4'b1000}) begin errors++; $display("FAIL flush_state: got lvl=%0d e/f/o/u=%b expected 0/1000", water_level, {rd_empty, wr_full, overflow, underflow}); end
         step(0, 0, 0, 0, '0);
      end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] w;
      for (int i = 0; i < 17; i++) step(1, 0, 0, 0, rand_word());
      step(1, 0, 0, 1, rand_word());
      checks++; if ({water_level, wr_full, almost_full, rd_empty, almost_empty, rd_valid, overflow, underflow} !== {(AW+1)'(0), 7'b0011000}) begin errors++; $display("FAIL rstmid_state: got lvl=%0d flags=%b", water_level, {wr_full, almost_full, rd_empty, almost_empty, rd_valid, overflow, underflow}); end
      checks++; if (rd_data !== '0) begin errors++; $display("FAIL rstmid_rd_data: got %h expected 0", rd_data); end
      w = rand_word();
      step(1, 0, 0, 0, w);
      for (int i = 0; i < 4; i++) begin
         step(0, i == 0, 0, 0, '0);
         checks++; if (rd_valid !== m_rdv || rd_data !== m_rdd) begin errors++; $display("FAIL rstmid_out: got v=%b d=%h expected v=%b d=%h", rd_valid, rd_data, m_rdv, m_rdd); end
      end
      checks++; if (rd_data !== w) begin errors++; $display("FAIL rstmid_word: got %h expected %h", rd_data, w); end
   endtask

   task automatic test_random();
      bit w, r, f, s;
      for (int i = 0; i < 600; i++) begin
         w = (i < 300) ? ($urandom_range(0, 99) < 70) : ($urandom_range(0, 99) < 35);
         r = (i < 300) ? ($urandom_range(0, 99) < 35) : ($urandom_range(0, 99) < 70);
         f = ($urandom_range(0, 149) == 0);
         s = ($urandom_range(0, 299) == 0);
         step(w, r, f, s, rand_word());
         checks++; if (water_level !== (AW+1)'(mq.size())) begin errors++; $display("FAIL rand_level cyc=%0d: got %0d expected %0d", cyc, water_level, mq.size()); end
         checks++; if ({wr_full, almost_full, rd_empty, almost_empty, overflow, underflow} !== exp_flags()) begin errors++; $display("FAIL rand_flags cyc=%0d: got %b expected %b", cyc, {wr_full, almost_full, rd_empty, almost_empty, overflow, underflow}, exp_flags()); end
         checks++; if (rd_valid !== m_rdv || rd_data !== m_rdd) begin errors++; $display("FAIL rand_out cyc=%0d: got v=%b d=%h expected v=%b d=%h", cyc, rd_valid, rd_data, m_rdv, m_rdd); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
      m_rdd = '0;
      #1;
      test_reset();
      test_fill();
      test_overflow_drain();
      test_wrap();
      test_underflow();
      test_flush();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pix_sync_fifo.md
PIX_SYNC_FIFO -- requirements
Module: pix_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 240: entry width in bits, legal range 1..1152.
REQ-002 SHALL have parameter DEPTH_WIDTH, default 5: depth is 2^DEPTH_WIDTH entries, legal range 2..12.
REQ-003 SHALL have parameter OUTPUT_REG, default 1: 1 adds an output register stage to the read path.
REQ-004 SHALL have parameter ALMOST_FULL_NUM, default 25: almost_full threshold, legal range 1..2^DEPTH_WIDTH.
REQ-005 SHALL have parameter ALMOST_EMPTY_NUM, default 6: almost_empty threshold, legal range 0..2^DEPTH_WIDTH-1.
REQ-006 SHALL have one clock and a synchronous, active-high reset.
REQ-007 clk  input  1  single clock; all logic on its rising edge.
REQ-008 rst  input  1  synchronous reset, active-high.
REQ-009 flush  input  1  synchronous clear of contents without reset.
REQ-010 wr_en  input  1  write request.
REQ-011 wr_data  input  DATA_WIDTH  write data.
REQ-012 wr_full  output  1  FIFO full.
REQ-013 almost_full  output  1  level >= ALMOST_FULL_NUM.
REQ-014 rd_en  input  1  read request.
REQ-015 rd_data  output  DATA_WIDTH  read data.
REQ-016 rd_valid  output  1  rd_data holds a valid popped word this cycle.
REQ-017 rd_empty  output  1  FIFO empty.
REQ-018 almost_empty  output  1  level <= ALMOST_EMPTY_NUM.
REQ-019 water_level  output  DEPTH_WIDTH+1  current entry count, 0..2^DEPTH_WIDTH.
REQ-020 overflow  output  1  sticky: a write was attempted while full.
REQ-021 underflow  output  1  sticky: a read was attempted while empty.

Function
REQ-022 Write acceptance SHALL occur iff wr_en=1 and wr_full=1'b0 at the clock edge; the word is stored at wr_ptr, and wr_ptr increments modulo 2^DEPTH_WIDTH.
REQ-023 Read acceptance SHALL occur iff rd_en=1 and rd_empty=1'b0 at the clock edge; rd_ptr increments modulo 2^DEPTH_WIDTH.
REQ-024 A read accepted at edge N SHALL present the popped word on rd_data with rd_valid=1 after edge N+1 when OUTPUT_REG=0, and after edge N+2 when OUTPUT_REG=1.
REQ-025 rd_valid SHALL be a one-cycle pulse per accepted read; rd_data SHALL hold its last value while rd_valid=0.
REQ-026 water_level SHALL be a registered count: +1 on write-only acceptance, -1 on read-only acceptance, unchanged when both or neither are accepted.
REQ-027 wr_full, rd_empty, almost_full and almost_empty SHALL be registered, derived from the next water_level value, and valid in the cycle following the operation that changes them.
REQ-028 A write and read both requested while full: the read SHALL be accepted, the write rejected, and overflow set.
REQ-029 A write and read both requested while empty: the write SHALL be accepted, the read rejected, and underflow set.
REQ-030 overflow and underflow SHALL remain set until rst or flush.
REQ-031 Rejected operations SHALL NOT modify pointers, storage or water_level.
REQ-032 flush SHALL take priority over wr_en and rd_en in the same cycle.
REQ-033 On flush, after the edge: pointers and water_level = 0, rd_empty=1, wr_full=0, flags recomputed, sticky bits cleared, and any in-flight rd_valid in the output pipeline cancelled.
REQ-034 Pointer wrap-around SHALL be transparent: data order SHALL be preserved across any number of wraps.

Reset
REQ-035 On rst=1 at an edge, the block SHALL set: water_level=0, rd_empty=1, almost_empty=1, wr_full=0, almost_full=0, rd_valid=0, rd_data=0, overflow=0, underflow=0, and both pointers=0.
REQ-036 Reset mid-operation SHALL discard all stored and in-flight data; rst SHALL take priority over flush, wr_en and rd_en.
REQ-037 Storage array contents SHALL NOT require reset.

Structure
REQ-038 The shared package pix_fifo_pkg SHALL hold the default width and depth constants and the threshold-legality check function.
REQ-039 Storage SHALL be one sub-module, pix_fifo_ram: simple dual-port, one write port and one registered read port, inferable as block RAM.
REQ-040 Elaboration SHALL fail if ALMOST_EMPTY_NUM >= ALMOST_FULL_NUM.

Verification (DEPTH_WIDTH=5, DATA_WIDTH=240)
REQ-041 Write 32 incrementing words with no reads -> wr_full=1 after the 32nd edge, almost_full=1 from level 25, water_level=32, overflow=0.
REQ-042 Attempt a 33rd write, then read all 32 -> overflow=1; rd_data sequence 0..31 with rd_valid 2 cycles after each rd_en (OUTPUT_REG=1); rd_empty=1 at the end.
REQ-043 Simultaneous wr_en and rd_en at level 10 for 100 cycles -> water_level stays 10; output order correct across 3 pointer wraps.
REQ-044 rd_en on an empty FIFO together with wr_en -> write accepted, underflow=1, water_level=1, no rd_valid pulse.
REQ-045 Flush at level 20 with 2 reads in flight -> no rd_valid after the flush edge, water_level=0, rd_empty=1, sticky bits=0.
REQ-046 rst asserted at level 17 alongside wr_en=1 -> all outputs at REQ-035 values the next cycle, and the write is discarded.
